// File: rtl/bcd_adder_seq.sv
// Sequential BCD adder, one decimal digit per clock, with registered seven-segment outputs.
// Optional BCD_SUB_EN enables nine's-complement subtraction through the sub port.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | waiting for start; operands, cin and sub captured on start
// S_CHECK | validate all captured digits, seed the carry
// S_ADD   | one digit per cycle, then one cycle to resolve the carry digit
// S_DONE  | one-cycle done pulse; results were loaded on entry
module bcd_adder_seq #(
  parameter int DIGITS = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [4*DIGITS-1:0]       a,
  input  logic [4*DIGITS-1:0]       b,
  input  logic                      cin,
  input  logic                      sub,
  output logic                      busy,
  output logic                      done,
  output logic [4*DIGITS-1:0]       sum,
  output logic                      cout,
  output logic                      err,
  output logic [7*(DIGITS+1)-1:0]   hex
);

  localparam int IW = $clog2(DIGITS + 2);

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b1111110;

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_ADD, S_DONE} state_t;

  state_t state, state_nx;

  logic [4*DIGITS-1:0]     a_r, b_r, acc;
  logic                    cin_r, carry;
  logic [IW-1:0]           idx;
  logic [3:0]              a_d, b_d, b_e, s_d;
  logic [4:0]              t;
  logic                    c_nx, bad, last;
  logic [7*(DIGITS+1)-1:0] hex_nx;

`ifdef BCD_SUB_EN
  logic sub_r;
`else
  logic unused_sub;
  assign unused_sub = sub;
`endif

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b0000001;
      4'd1:    seg7 = 7'b1001111;
      4'd2:    seg7 = 7'b0010010;
      4'd3:    seg7 = 7'b0000110;
      4'd4:    seg7 = 7'b1001100;
      4'd5:    seg7 = 7'b0100100;
      4'd6:    seg7 = 7'b0100000;
      4'd7:    seg7 = 7'b0001111;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0000100;
      default: seg7 = SEG_BLANK;
    endcase
  endfunction

  always_comb begin
    a_d = '0;
    b_d = '0;
    bad = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx == IW'(k)) begin
        a_d = a_r[4*k +: 4];
        b_d = b_r[4*k +: 4];
      end
      bad = bad | (a_r[4*k +: 4] > 4'd9) | (b_r[4*k +: 4] > 4'd9);
    end
    last = (idx == IW'(DIGITS));
  end

  always_comb begin
`ifdef BCD_SUB_EN
    b_e = sub_r ? (4'd9 - b_d) : b_d;
`else
    b_e = b_d;
`endif
    t = {1'b0, a_d} + {1'b0, b_e} + {4'b0000, carry};
    if (t > 5'd9) begin
      s_d  = t[3:0] + 4'd6;
      c_nx = 1'b1;
    end else begin
      s_d  = t[3:0];
      c_nx = 1'b0;
    end
  end

  always_comb begin
    hex_nx = '1;
    for (int k = 0; k < DIGITS; k++)
      hex_nx[7*k +: 7] = seg7(acc[4*k +: 4]);
`ifdef BCD_SUB_EN
    if (sub_r)
      hex_nx[7*DIGITS +: 7] = carry ? SEG_BLANK : SEG_MINUS;
    else
      hex_nx[7*DIGITS +: 7] = seg7({3'b000, carry});
`else
    hex_nx[7*DIGITS +: 7] = seg7({3'b000, carry});
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = S_CHECK;
      S_CHECK: state_nx = bad ? S_DONE : S_ADD;
      S_ADD:   if (last) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    busy = (state != S_IDLE);
    done = (state == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r   <= '0;
      b_r   <= '0;
      acc   <= '0;
      cin_r <= 1'b0;
      carry <= 1'b0;
      idx   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      err   <= 1'b0;
      hex   <= '1;
`ifdef BCD_SUB_EN
      sub_r <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: if (start) begin
          a_r   <= a;
          b_r   <= b;
          cin_r <= cin;
          idx   <= '0;
`ifdef BCD_SUB_EN
          sub_r <= sub;
`endif
        end
        S_CHECK: begin
`ifdef BCD_SUB_EN
          carry <= sub_r ? ~cin_r : cin_r;
`else
          carry <= cin_r;
`endif
          if (bad) begin
            sum  <= '0;
            cout <= 1'b0;
            err  <= 1'b1;
            hex  <= '1;
          end
        end
        S_ADD: begin
          if (!last) begin
            for (int k = 0; k < DIGITS; k++)
              if (idx == IW'(k)) acc[4*k +: 4] <= s_d;
            carry <= c_nx;
            idx   <= idx + 1'b1;
          end else begin
            // Final cycle: every digit is in acc and carry is the decimal carry-out
            sum  <= acc;
            cout <= carry;
            err  <= 1'b0;
            hex  <= hex_nx;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_adder_seq.sv
// Directed self-checking bench for bcd_adder_seq (DIGITS=2).
// Build with BCD_SUB_EN defined to exercise the subtract vectors.
module tb_bcd_adder_seq;

  localparam int DIGITS = 2;

  logic        clk = 1'b0;
  logic        rst, start, cin, sub;
  logic [7:0]  a, b;
  logic        busy, done, cout, err;
  logic [7:0]  sum;
  logic [20:0] hex;

  int errors = 0;
  int checks = 0;

  bcd_adder_seq #(.DIGITS(DIGITS)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin), .sub(sub),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .err(err), .hex(hex)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!done && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic run_op(input string tag, input logic [7:0] av, input logic [7:0] bv,
                        input logic ci, input logic sb, input int exp_cyc,
                        input logic [7:0] es, input logic ec, input logic ee,
                        input logic [20:0] eh);
    int cyc;
    @(negedge clk);
    a = av; b = bv; cin = ci; sub = sb; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = 8'hFF; b = 8'hFF; cin = ~ci; sub = ~sb;
    check({tag, ".busy"}, busy, 1);
    wait_done(cyc);
    check({tag, ".latency"}, cyc, exp_cyc);
    check({tag, ".sum"}, sum, es);
    check({tag, ".cout"}, cout, ec);
    check({tag, ".err"}, err, ee);
    check({tag, ".hex"}, hex, eh);
    @(posedge clk); #1;
    check({tag, ".done_pulse"}, done, 0);
    check({tag, ".idle"}, busy, 0);
    check({tag, ".hold"}, sum, es);
  endtask

  initial begin
    int cyc, n;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    #12;
    check("rst.busy", busy, 0);
    check("rst.done", done, 0);
    check("rst.sum", sum, 0);
    check("rst.cout", cout, 0);
    check("rst.err", err, 0);
    check("rst.hex", hex, 21'h1FFFFF);
    @(negedge clk); rst = 1'b0;

    run_op("add45_37", 8'h45, 8'h37, 1'b0, 1'b0, 4, 8'h82, 1'b0, 1'b0,
           {7'b0000001, 7'b0000000, 7'b0010010});
    run_op("add99_99", 8'h99, 8'h99, 1'b1, 1'b0, 4, 8'h99, 1'b1, 1'b0,
           {7'b1001111, 7'b0000100, 7'b0000100});
    run_op("add50_50", 8'h50, 8'h50, 1'b0, 1'b0, 4, 8'h00, 1'b1, 1'b0,
           {7'b1001111, 7'b0000001, 7'b0000001});
    run_op("err_a", 8'h4A, 8'h12, 1'b0, 1'b0, 1, 8'h00, 1'b0, 1'b1, 21'h1FFFFF);
    run_op("err_b", 8'h12, 8'hB0, 1'b1, 1'b0, 1, 8'h00, 1'b0, 1'b1, 21'h1FFFFF);
    run_op("clr_err", 8'h12, 8'h34, 1'b1, 1'b0, 4, 8'h47, 1'b0, 1'b0,
           {7'b0000001, 7'b1001100, 7'b0001111});
`ifdef BCD_SUB_EN
    run_op("sub30_45", 8'h30, 8'h45, 1'b0, 1'b1, 4, 8'h85, 1'b0, 1'b0,
           {7'b1111110, 7'b0000000, 7'b0100100});
    run_op("sub45_30", 8'h45, 8'h30, 1'b0, 1'b1, 4, 8'h15, 1'b1, 1'b0,
           {7'b1111111, 7'b1001111, 7'b0100100});
    run_op("sub45_30b", 8'h45, 8'h30, 1'b1, 1'b1, 4, 8'h14, 1'b1, 1'b0,
           {7'b1111111, 7'b1001111, 7'b1001100});
`else
    run_op("sub_ignored", 8'h30, 8'h45, 1'b0, 1'b1, 4, 8'h75, 1'b0, 1'b0,
           {7'b0000001, 7'b0001111, 7'b0100100});
`endif

    // second start while adding must not create another request
    @(negedge clk);
    a = 8'h21; b = 8'h13; cin = 1'b0; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (done) n++;
    end
    check("start_in_add.pulses", n, 1);
    check("start_in_add.sum", sum, 8'h34);

    // start held through DONE is ignored there, accepted on the following IDLE cycle
    @(negedge clk);
    a = 8'h08; b = 8'h07; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    wait_done(cyc);
    check("hold_done.latency", cyc, 4);
    start = 1'b1;
    @(posedge clk); #1;
    check("hold_done.ignored", busy, 0);
    @(posedge clk); #1;
    start = 1'b0;
    check("hold_done.accepted", busy, 1);
    wait_done(cyc);
    check("hold_done.latency2", cyc, 4);
    check("hold_done.sum", sum, 8'h15);

    // reset during ADD aborts the request
    @(posedge clk); #1;
    @(negedge clk);
    a = 8'h56; b = 8'h27; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("rst_add.busy", busy, 0);
    check("rst_add.done", done, 0);
    check("rst_add.sum", sum, 0);
    check("rst_add.hex", hex, 21'h1FFFFF);
    @(negedge clk); rst = 1'b0;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (done || busy) n++;
    end
    check("rst_add.no_done", n, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
